// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM states and constants for the data-memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int CNT_W = 4;
endpackage

// File: rtl/byte_ram.sv
// byte_ram: DEPTH_WORDS x 32 RAM, per-byte write enables (we, be, waddr, wdata), registered read (raddr -> rdata), no reset
module byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder (mem_req/mem_write/alu_out_M/byte_en/write_data_M in; read_data_M/data_mem_ack/mem_err/busy out) with wait states and window check
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BAD_DATA    = BAD_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [31:0] alu_out_M,
  input  logic [3:0]  byte_en,
  input  logic [31:0] write_data_M,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack,
  output logic        mem_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN = 32'(DEPTH_WORDS * 4);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0] off, wd_q, ram_q;
  logic [AW-1:0] idx_q;
  logic [3:0] be_q;
  logic wr_q, in_win_q, capture, in_win;
  // Base is aligned to the window size, so an address below base wraps to a huge offset and fails the same compare.
  assign off = alu_out_M - ADDR_BASE;
  assign in_win = off < WIN;
  assign capture = state == IDLE && mem_req;
  always_comb begin
    state_n = state == IDLE ? (mem_req ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (cnt == CNT_W'(1) ? RESP : WAIT)
            : IDLE;
    cnt_n = capture ? CNT_W'(WAIT_STATES) : state == WAIT ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
    if (capture) begin
      idx_q <= off[AW+1:2];
      wr_q <= mem_write;
      be_q <= byte_en;
      wd_q <= write_data_M;
      in_win_q <= in_win;
    end
  end
  // Read the live index while idle so a zero-wait access has its word ready in RESP.
  byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk  (clk),
    .we   (state == RESP && wr_q && in_win_q && !reset),
    .be   (be_q),
    .waddr(idx_q),
    .wdata(wd_q),
    .raddr(state == IDLE ? off[AW+1:2] : idx_q),
    .rdata(ram_q)
  );
  // Reset during RESP aborts the access, so the ack is suppressed in that cycle too.
  assign data_mem_ack = state == RESP && !reset;
  assign mem_err = data_mem_ack && !in_win_q;
  assign busy = state != IDLE;
  assign read_data_M = (data_mem_ack && !wr_q) ? (in_win_q ? ram_q : BAD_DATA) : '0;
endmodule
